// File: rtl/adc_sample_ctrl.sv
// ============================================================================
// Module   : adc_sample_ctrl
// Purpose  : Paced WR/INTR/RD sequencer for an 8-bit parallel ADC that
//            averages 2^AVG_LOG2 conversions into one output word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adc_sample_ctrl #(
  parameter int DIV       = 1000,
  parameter int WR_CYCLES = 4,
  parameter int RD_CYCLES = 4,
  parameter int TIMEOUT   = 2048,
  parameter int AVG_LOG2  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] adc_db,
  input  logic       intr_n,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] adc_data,
  output logic       data_valid,
  output logic       timeout
);

  localparam int c_tmr_w  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int c_ph_max = (TIMEOUT > WR_CYCLES)
                          ? ((TIMEOUT > RD_CYCLES) ? TIMEOUT : RD_CYCLES)
                          : ((WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES);
  localparam int c_cnt_w  = $clog2(c_ph_max + 1);
  localparam int c_acc_w  = 8 + AVG_LOG2;
  localparam int c_num_w  = AVG_LOG2 + 1;

  localparam logic [c_tmr_w-1:0] c_div_last = c_tmr_w'(DIV - 1);
  localparam logic [c_cnt_w-1:0] c_wr_last  = c_cnt_w'(WR_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_rd_last  = c_cnt_w'(RD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_num_w-1:0] c_avg_n    = c_num_w'(1 << AVG_LOG2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_READ  = 3'd3,
    S_ACCUM = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [c_tmr_w-1:0]   timer_q, timer_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [7:0]           sample_q, sample_d;
  logic [c_acc_w-1:0]   acc_q, acc_d;
  logic [c_num_w-1:0]   num_q, num_d;
  logic [7:0]           adc_data_q, adc_data_d;
  logic                 data_valid_q, data_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 cs_n_q, cs_n_d;
  logic                 wr_n_q, wr_n_d;
  logic                 rd_n_q, rd_n_d;
  logic                 intr_s1_q, intr_s2_q;

  logic                 tick;
  logic [c_acc_w-1:0]   acc_sum;
  logic [c_num_w-1:0]   num_next;

  // The timer runs independently of the FSM; ticks outside IDLE are simply lost.
  assign tick = en && (timer_q == c_div_last);

  always_comb begin
    timer_d = timer_q;
    if (!en) begin
      timer_d = '0;
    end else if (timer_q == c_div_last) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + c_tmr_w'(1);
    end
  end

  assign acc_sum  = acc_q + c_acc_w'(sample_q);
  assign num_next = num_q + c_num_w'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sample_d     = sample_q;
    acc_d        = acc_q;
    num_d        = num_q;
    adc_data_d   = adc_data_q;
    data_valid_d = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tick) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == c_wr_last) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_WAIT: begin
        if (!intr_s2_q) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == c_to_last) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_READ: begin
        if (cnt_q == c_rd_last) begin
          sample_d = adc_db;
          state_d  = S_ACCUM;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + c_cnt_w'(1);
        end
      end
      S_ACCUM: begin
        state_d = S_IDLE;
        if (num_next == c_avg_n) begin
          adc_data_d   = 8'(acc_sum >> AVG_LOG2);
          data_valid_d = 1'b1;
          acc_d        = '0;
          num_d        = '0;
        end else begin
          acc_d = acc_sum;
          num_d = num_next;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Strobes are registered from the next state so they line up with it.
    cs_n_d = !((state_d == S_START) || (state_d == S_WAIT) || (state_d == S_READ));
    wr_n_d = (state_d != S_START);
    rd_n_d = (state_d != S_READ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      cnt_q        <= '0;
      sample_q     <= '0;
      acc_q        <= '0;
      num_q        <= '0;
      adc_data_q   <= '0;
      data_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      cs_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      intr_s1_q    <= 1'b1;
      intr_s2_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      acc_q        <= acc_d;
      num_q        <= num_d;
      adc_data_q   <= adc_data_d;
      data_valid_q <= data_valid_d;
      timeout_q    <= timeout_d;
      cs_n_q       <= cs_n_d;
      wr_n_q       <= wr_n_d;
      rd_n_q       <= rd_n_d;
      intr_s1_q    <= intr_n;
      intr_s2_q    <= intr_s1_q;
    end
  end

  assign cs_n       = cs_n_q;
  assign wr_n       = wr_n_q;
  assign rd_n       = rd_n_q;
  assign adc_data   = adc_data_q;
  assign data_valid = data_valid_q;
  assign timeout    = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_sample_ctrl.sv
// ============================================================================
// Module   : tb_adc_sample_ctrl
// Purpose  : Directed self-checking bench for adc_sample_ctrl with a simple
//            ADC0804-style converter model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adc_sample_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] adc_db;
  logic       intr_n;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] adc_data;
  logic       data_valid;
  logic       timeout;

  int total;
  int bad;
  int dv_count;
  logic adc_respond;
  logic wr_prev;
  int   dly;

  adc_sample_ctrl #(
    .DIV       (40),
    .WR_CYCLES (2),
    .RD_CYCLES (2),
    .TIMEOUT   (50),
    .AVG_LOG2  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .adc_db     (adc_db),
    .intr_n     (intr_n),
    .cs_n       (cs_n),
    .wr_n       (wr_n),
    .rd_n       (rd_n),
    .adc_data   (adc_data),
    .data_valid (data_valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter: end-of-conversion 10 cycles after wr_n rises, cleared by rd_n.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      intr_n  <= 1'b1;
      dly     <= -1;
      wr_prev <= 1'b1;
    end else begin
      wr_prev <= wr_n;
      if (rd_n == 1'b0) intr_n <= 1'b1;
      if (wr_prev == 1'b0 && wr_n == 1'b1 && adc_respond) dly <= 9;
      else if (dly > 0) dly <= dly - 1;
      else if (dly == 0) begin
        intr_n <= 1'b0;
        dly    <= -1;
      end
    end
  end

  always @(negedge clk) begin
    if (data_valid === 1'b1) dv_count <= dv_count + 1;
  end

  task automatic convert(input logic [7:0] v, input int exp_dv,
                         input logic [7:0] exp_data, input string nm);
    int base;
    int k;
    adc_db = v;
    base   = dv_count;
    k = 0;
    while (rd_n !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 300) begin
      bad++;
      $display("FAIL %s_rd_start: rd_n=%b after %0d cycles, required 0", nm, rd_n, k);
    end
    k = 0;
    while (rd_n !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ((dv_count - base) !== exp_dv) begin
      bad++;
      $display("FAIL %s_valid: data_valid pulses=%0d, required %0d", nm, dv_count - base, exp_dv);
    end
    total++;
    if (adc_data !== exp_data) begin
      bad++;
      $display("FAIL %s_data: adc_data=%0d, required %0d", nm, adc_data, exp_data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cs_n, wr_n, rd_n} !== 3'b111) begin
      bad++;
      $display("FAIL reset_strobes: cs/wr/rd=%b, required 111", {cs_n, wr_n, rd_n});
    end
    total++;
    if (adc_data !== 8'd0 || data_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: data=%0d dv=%b to=%b, required 0 0 0", adc_data, data_valid, timeout);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_average();
    en = 1'b1;
    convert(8'd30,  0, 8'd0,  "avg1");
    convert(8'd234, 0, 8'd0,  "avg2");
    convert(8'd40,  0, 8'd0,  "avg3");
    convert(8'd50,  1, 8'd88, "avg4");
  endtask

  task automatic test_saturate_truncate();
    convert(8'd255, 0, 8'd88,  "sat1");
    convert(8'd255, 0, 8'd88,  "sat2");
    convert(8'd255, 0, 8'd88,  "sat3");
    convert(8'd255, 1, 8'd255, "sat4");
    convert(8'd1,   0, 8'd255, "trunc1");
    convert(8'd1,   0, 8'd255, "trunc2");
    convert(8'd1,   0, 8'd255, "trunc3");
    convert(8'd2,   1, 8'd1,   "trunc4");
  endtask

  task automatic test_timeout();
    int k;
    int base;
    logic cs_before;
    convert(8'd10, 0, 8'd1, "to_pre");
    adc_respond = 1'b0;
    base = dv_count;
    k = 0;
    while (wr_n !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    while (wr_n !== 1'b1 && k < 110) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    cs_before = 1'b1;
    while (timeout !== 1'b1 && k < 200) begin
      cs_before = cs_n;
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== 50) begin
      bad++;
      $display("FAIL timeout_delay: pulse after %0d WAIT cycles, required 50", k);
    end
    total++;
    if (cs_before !== 1'b0) begin
      bad++;
      $display("FAIL timeout_cs_wait: cs_n=%b in last WAIT cycle, required 0", cs_before);
    end
    total++;
    if ({cs_n, wr_n, rd_n} !== 3'b111) begin
      bad++;
      $display("FAIL timeout_strobes: cs/wr/rd=%b, required 111", {cs_n, wr_n, rd_n});
    end
    @(negedge clk);
    total++;
    if (timeout !== 1'b0 || dv_count !== base) begin
      bad++;
      $display("FAIL timeout_pulse: timeout=%b dv_pulses=%0d, required 0 0", timeout, dv_count - base);
    end
    adc_respond = 1'b1;
    convert(8'd20, 0, 8'd1,  "to_post1");
    convert(8'd30, 0, 8'd1,  "to_post2");
    convert(8'd40, 1, 8'd25, "to_post3");
  endtask

  task automatic test_strobes();
    int k;
    int wr_len;
    int rd_len;
    int overlap;
    int cs_bad;
    adc_db = 8'd7;
    k = 0;
    while (wr_n !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    wr_len = 0; rd_len = 0; overlap = 0; cs_bad = 0;
    for (int i = 0; i < 35; i++) begin
      if (wr_n === 1'b0) wr_len++;
      if (rd_n === 1'b0) rd_len++;
      if (wr_n === 1'b0 && rd_n === 1'b0) overlap++;
      if ((wr_n === 1'b0 || rd_n === 1'b0) && cs_n !== 1'b0) cs_bad++;
      @(negedge clk);
    end
    total++;
    if (wr_len !== 2) begin
      bad++;
      $display("FAIL strobe_wr_width: wr_n low %0d cycles, required 2", wr_len);
    end
    total++;
    if (rd_len !== 2) begin
      bad++;
      $display("FAIL strobe_rd_width: rd_n low %0d cycles, required 2", rd_len);
    end
    total++;
    if (overlap !== 0 || cs_bad !== 0) begin
      bad++;
      $display("FAIL strobe_overlap: overlap=%0d cs_gaps=%0d, required 0 0", overlap, cs_bad);
    end
  endtask

  task automatic test_en_drop();
    int k;
    int wr_seen;
    int base;
    adc_db = 8'd9;
    base = dv_count;
    k = 0;
    while (wr_n !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    while (wr_n !== 1'b1 && k < 110) begin
      @(negedge clk);
      k++;
    end
    en = 1'b0;
    k = 0;
    while (rd_n !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k >= 100) begin
      bad++;
      $display("FAIL endrop_complete: rd_n=%b after en drop, required 0", rd_n);
    end
    wr_seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (wr_n === 1'b0) wr_seen++;
    end
    total++;
    if (wr_seen !== 0 || dv_count !== base) begin
      bad++;
      $display("FAIL endrop_idle: wr_n low %0d cycles dv=%0d, required 0 0", wr_seen, dv_count - base);
    end
    adc_db = 8'd8;
    en = 1'b1;
    k = 0;
    while (wr_n !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (k !== 40) begin
      bad++;
      $display("FAIL endrop_restart: START after %0d cycles, required 40", k);
    end
    convert(8'd8,  0, 8'd25, "endrop1");
    convert(8'd16, 1, 8'd10, "endrop2");
  endtask

  task automatic test_reset_mid_read();
    int k;
    int base;
    adc_db = 8'd50;
    k = 0;
    while (rd_n !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    base = dv_count;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({cs_n, wr_n, rd_n} !== 3'b111) begin
      bad++;
      $display("FAIL midread_strobes: cs/wr/rd=%b, required 111", {cs_n, wr_n, rd_n});
    end
    total++;
    if (adc_data !== 8'd0 || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL midread_data: data=%0d dv=%b, required 0 0", adc_data, data_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (dv_count !== base || adc_data !== 8'd0) begin
      bad++;
      $display("FAIL midread_after: dv=%0d data=%0d, required 0 0", dv_count - base, adc_data);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    dv_count    = 0;
    adc_respond = 1'b1;
    adc_db      = 8'd0;
    en          = 1'b0;
    rst         = 1'b1;
    test_reset();
    test_average();
    test_saturate_truncate();
    test_timeout();
    test_strobes();
    test_en_drop();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adc_sample_ctrl.md
# adc_sample_ctrl

Sequencer for the external 8-bit parallel ADC (ADC0804-style WR/INTR/RD handshake) that feeds `adc_top`. It paces conversions from a programmable sample timer, drives the chip-select/write/read strobes, waits on the converter's end-of-conversion flag with a timeout, and averages 2^AVG_LOG2 readings into the 8-bit `adc_data` word consumed by `adc_top`. One conversion is in flight at a time.

## Interface
- DIV, 1000: sample period in clk cycles (≥ 4)
- WR_CYCLES, 4: clk cycles `wr_n` is held low (≥ 1)
- RD_CYCLES, 4: clk cycles `rd_n` is held low (≥ 1)
- TIMEOUT, 2048: max clk cycles waited for `intr_n` low
- AVG_LOG2, 2: log2 of samples averaged per output (0..4)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  enable sample timer
- adc_db  in  8  ADC parallel data bus
- intr_n  in  1  ADC end-of-conversion, active low, asynchronous
- cs_n  out  1  ADC chip select, active low
- wr_n  out  1  start-conversion strobe, active low
- rd_n  out  1  read strobe, active low
- adc_data  out  8  averaged sample to `adc_top`
- data_valid  out  1  one-cycle pulse, `adc_data` updated
- timeout  out  1  one-cycle pulse, conversion abandoned

## Operation
- Reset (async, any state): state IDLE; `cs_n`=`wr_n`=`rd_n`=1; `adc_data`=0; `data_valid`=0; `timeout`=0; timer, accumulator, sample count, sync flops cleared (sync flops to 1).
- Sample timer: counts 0..DIV-1 while `en`=1, wraps; `tick` when count = DIV-1. `en`=0 holds timer at 0. Tick not in IDLE is dropped (no queuing).
- `intr_n` passes through a 2-flop synchronizer (reset value 1) before use.
- States:
  - IDLE: strobes high. `tick` -> START.
  - START: `cs_n`=0, `wr_n`=0 for exactly WR_CYCLES cycles -> WAIT.
  - WAIT: `cs_n`=0, `wr_n`=1. Synchronized `intr_n`=0 -> READ. Wait counter reaches TIMEOUT -> `timeout` pulse, sample discarded, accumulator untouched -> IDLE.
  - READ: `cs_n`=0, `rd_n`=0 for exactly RD_CYCLES cycles; `adc_db` latched on the last READ cycle -> ACCUM.
  - ACCUM: strobes high; acc += sample; count++. If count reaches 2^AVG_LOG2: `adc_data` <= acc_total >> AVG_LOG2, `data_valid` pulses, acc and count cleared. -> IDLE.
- Accumulator width 8+AVG_LOG2; no overflow possible. Division truncates.
- `en` falling mid-conversion: current conversion completes; no new ticks.
- `adc_data` holds its value between `data_valid` pulses.

## Timing
- Tick at cycle T: START occupies T+1..T+WR_CYCLES; WAIT begins T+WR_CYCLES+1.
- `intr_n` low sampled at edge E: READ entered at E+2 (synchronizer) +1 state transition.
- `data_valid` asserted the cycle after ACCUM when count completes, coincident with new `adc_data`.
- Timeout: `timeout` pulse on the cycle after TIMEOUT cycles spent in WAIT; `cs_n` high the same cycle.
- All outputs registered; no combinational path from inputs to outputs.
- Minimum conversion length WR_CYCLES+RD_CYCLES+5; DIV smaller than this drops every other tick (legal).

## Test plan
(bench params DIV=40, WR_CYCLES=2, RD_CYCLES=2, TIMEOUT=50, AVG_LOG2=2; ADC model pulls `intr_n` low 10 cycles after `wr_n` rises, releases on `rd_n` low)
- Reset mid-READ: assert `rst` -> `cs_n`,`wr_n`,`rd_n` go 1 without waiting for clk; `adc_data`=0, no `data_valid`.
- Samples 30, 234, 40, 50 -> one `data_valid` after 4th sample, `adc_data`=88 (354>>2); no pulse after samples 1-3.
- Four samples of 255 -> `adc_data`=255; then 1,1,1,2 -> `adc_data`=1 (truncation).
- `intr_n` held high -> `timeout` pulse 50 cycles into WAIT, strobes high, no `data_valid`; next tick converts normally and accumulator count continues from before.
- Strobe widths: `wr_n` low exactly 2 cycles, `rd_n` low exactly 2 cycles, `cs_n` low covering both; `wr_n` and `rd_n` never low together.
- `en` dropped during WAIT -> conversion completes (sample accumulated), no further `wr_n` pulses while `en`=0; re-enable -> first START DIV cycles later.
